// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2 stride-2 max-pool with per-output argmax.
// One half-width line buffer holds the top-row pair maxima between rows.
module relu_maxpool2x2 #(
   parameter int unsigned FM_W   = 62,
   parameter int unsigned FM_H   = 62,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_argmax,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int unsigned P_W   = FM_W / 2;
   localparam int unsigned P_H   = FM_H / 2;
   localparam int unsigned COL_W = $clog2(FM_W) + 1;
   localparam int unsigned ROW_W = $clog2(FM_H) + 1;
   localparam int unsigned LB_AW = (P_W > 1) ? $clog2(P_W) : 1;
   localparam int unsigned LB_N  = 2 ** LB_AW;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic              dx;
      logic [DATA_W-1:0] val;
   } lb_entry_t;

   state_t            state, state_nxt;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              exhausted;
   logic [DATA_W-1:0] pair_val;
   lb_entry_t         line_buf [LB_N];

   logic              accept;
   logic              out_stall;
   logic              frame_start;
   logic [DATA_W-1:0] relu_val;
   logic              right_wins;
   logic [DATA_W-1:0] pair_max;
   logic [LB_AW-1:0]  lb_idx;
   lb_entry_t         top;
   logic              bottom_wins;
   logic              col_last;
   logic              row_last;
   logic              last_window;

   assign out_stall   = out_valid && !out_ready;
   assign in_ready    = (state == RUN) && !out_stall && !exhausted;
   assign accept      = in_valid && in_ready;
   assign frame_start = start && ((state == IDLE) || (state == DONE));
   assign busy        = (state == RUN);
   assign done        = (state == DONE);

   // After ReLU both operands are non-negative, so unsigned compares suffice.
   assign relu_val    = in_data[DATA_W-1] ? '0 : in_data;
   assign right_wins  = relu_val > pair_val;
   assign pair_max    = right_wins ? relu_val : pair_val;
   assign lb_idx      = LB_AW'(col >> 1);
   assign top         = line_buf[lb_idx];
   assign bottom_wins = pair_max > top.val;
   assign col_last    = (col == COL_W'(FM_W - 1));
   assign row_last    = (row == ROW_W'(FM_H - 1));
   assign last_window = (row == ROW_W'(2 * P_H - 1)) && (col == COL_W'(2 * P_W - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (exhausted && !out_stall) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Raster position of the next beat; exhausted blocks input after the last one.
   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         exhausted <= 1'b0;
      end else if (frame_start) begin
         col       <= '0;
         row       <= '0;
         exhausted <= 1'b0;
      end else if (accept) begin
         if (col_last) begin
            col <= '0;
            row <= row + ROW_W'(1);
            if (row_last) exhausted <= 1'b1;
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Left element of a pair, then top-row pair max; contents need no reset.
   always_ff @(posedge clk) begin
      if (accept && !col[0]) pair_val <= relu_val;
      if (accept && col[0] && !row[0]) line_buf[lb_idx] <= '{dx: right_wins, val: pair_max};
   end

   // Ties keep the earlier raster position: left over right, top over bottom.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_argmax <= 2'b00;
         out_last   <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (accept && col[0] && row[0]) begin
            out_valid  <= 1'b1;
            out_data   <= bottom_wins ? pair_max : top.val;
            out_argmax <= bottom_wins ? {1'b1, right_wins} : {1'b0, top.dx};
            out_last   <= last_window;
         end
      end
   end

endmodule
